// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// rv_pkg : shared core types for the integer divide unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// div_unit : iterative restoring radix-2 divider, one quotient bit per cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_unit
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  div_op_t         op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      rd_address,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [4:0]      write_address,
    output logic [XLEN-1:0] write_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] C_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      C_LAST_CNT = 6'(XLEN - 1);

    state_t          state_q;
    logic [5:0]      cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dsr_q;
    div_op_t         op_q;
    logic            neg_quo_q, neg_rem_q;
    logic [4:0]      rd_q;
    logic            done_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;

    logic            w_signed, w_a_neg, w_b_neg, w_ovf;
    logic [XLEN-1:0] w_abs_a, w_abs_b;
    logic [XLEN:0]   w_shift, w_diff;
    logic [XLEN-1:0] quo_d, rem_d, result_d;

    assign w_signed = (op == DIV) || (op == REM);
    assign w_a_neg  = w_signed && dividend[XLEN-1];
    assign w_b_neg  = w_signed && divisor[XLEN-1];
    assign w_abs_a  = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_abs_b  = w_b_neg ? (~divisor + 1'b1) : divisor;
    assign w_ovf    = w_signed && (dividend == C_MIN_NEG) && (divisor == '1);

    // The quotient register starts as the dividend and shifts its MSB into the remainder.
    always_comb begin
        w_shift = {rem_q, quo_q[XLEN-1]};
        w_diff  = w_shift - {1'b0, dsr_q};
        if (!w_diff[XLEN]) begin
            rem_d = w_diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = w_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if ((op_q == DIV) || (op_q == DIVU))
            result_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        else
            result_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            op_q      <= DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op;
                        rd_q  <= rd_address;
                        cnt_q <= '0;
                        // Special cases preload the final magnitudes and skip iteration.
                        if (divisor == '0) begin
                            quo_q     <= '1;
                            rem_q     <= dividend;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= FINISH;
                        end else if (w_ovf) begin
                            quo_q     <= C_MIN_NEG;
                            rem_q     <= '0;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= FINISH;
                        end else begin
                            quo_q     <= w_abs_a;
                            rem_q     <= '0;
                            dsr_q     <= w_abs_b;
                            neg_quo_q <= w_a_neg ^ w_b_neg;
                            neg_rem_q <= w_a_neg;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == C_LAST_CNT)
                            state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    if (!flush) begin
                        done_q  <= 1'b1;
                        waddr_q <= rd_q;
                        wdata_q <= result_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
//------------------------------------------------------------------------------
// tb_div_unit : directed and randomized checks of div_unit against an arithmetic model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    div_op_t     op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_address;
    logic        flush;
    logic        busy;
    logic        done;
    logic [4:0]  write_address;
    logic [31:0] write_data;

    int total = 0;
    int bad   = 0;

    div_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op            (op),
        .dividend      (dividend),
        .divisor       (divisor),
        .rd_address    (rd_address),
        .flush         (flush),
        .busy          (busy),
        .done          (done),
        .write_address (write_address),
        .write_data    (write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input div_op_t o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic sgn;
        logic isdiv;
        sa    = a;
        sb    = b;
        sgn   = (o == DIV) || (o == REM);
        isdiv = (o == DIV) || (o == DIVU);
        if (b == 32'd0) return isdiv ? 32'hFFFF_FFFF : a;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isdiv ? 32'h8000_0000 : 32'd0;
        if (sgn) return isdiv ? 32'(sa / sb) : 32'(sa % sb);
        return isdiv ? (a / b) : (a % b);
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation and returns in the cycle where done is seen high.
    task automatic do_op(input div_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string tag);
        logic [31:0] exp;
        int lat;
        int n;
        bit seen;
        exp = model(o, a, b);
        lat = (b == 32'd0 || ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b; rd_address = rd;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; rd_address = 5'($urandom);
        chk(32'(busy), 32'd1, {tag, ":busy"});
        chk(32'(done), 32'd0, {tag, ":done_low"});
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk(32'(seen), 32'd1, {tag, ":done_seen"});
        chk(32'(n), 32'(lat), {tag, ":latency"});
        chk(write_data, exp, {tag, ":data"});
        chk(32'(write_address), 32'(rd), {tag, ":waddr"});
    endtask

    task automatic watch_no_done(input int cycles, input string tag);
        int hits;
        hits = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done !== 1'b0) hits++;
        end
        chk(32'(hits), 32'd0, tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = DIV;
        dividend = '0; divisor = '0; rd_address = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(32'(busy), 32'd0, "rst_busy");
        chk(32'(done), 32'd0, "rst_done");
        chk(32'(write_address), 32'd0, "rst_waddr");
        chk(write_data, 32'd0, "rst_wdata");
        @(negedge clk);
        rst_n = 1'b1;

        do_op(DIVU, 32'd100, 32'd7, 5'd3, "divu_100_7");
        do_op(REMU, 32'd100, 32'd7, 5'd4, "remu_100_7");
        do_op(REM,  32'hFFFF_FFF9, 32'd2, 5'd5, "rem_m7_2");
        do_op(DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, "div_m7_2");
        do_op(DIV,  32'd1234, 32'd0, 5'd6, "div_by0");
        do_op(REM,  32'd1234, 32'd0, 5'd6, "rem_by0");
        do_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, "div_ovf");
        do_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "rem_ovf");
        do_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "divu_big");
        do_op(DIV,  32'd7, 32'hFFFF_FFFE, 5'd10, "div_7_m2");

        // Start during CALC is ignored, then the operation is flushed.
        @(negedge clk);
        start = 1'b1; op = DIVU; dividend = 32'd1000; divisor = 32'd3; rd_address = 5'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = REMU; dividend = 32'd9; divisor = 32'd2; rd_address = 5'd12;
        @(posedge clk); #1;
        start = 1'b0;
        chk(32'(busy), 32'd1, "calc_busy");
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk(32'(busy), 32'd0, "flush_busy");
        chk(32'(done), 32'd0, "flush_done");
        watch_no_done(40, "flush_no_done");

        // Flush together with start in IDLE blocks the start.
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = DIVU; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk(32'(busy), 32'd0, "flush_start_idle");
        watch_no_done(5, "flush_start_no_done");
        do_op(DIVU, 32'd1000, 32'd3, 5'd13, "after_flush");

        // Reset mid-CALC.
        @(negedge clk);
        start = 1'b1; op = DIV; dividend = 32'd999; divisor = 32'd9; rd_address = 5'd14;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk(32'(busy), 32'd0, "midrst_busy");
        chk(32'(done), 32'd0, "midrst_done");
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done(40, "midrst_no_done");

        for (int i = 0; i < 24; i++) begin
            div_op_t     ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = div_op_t'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = $urandom_range(1, 15);
                3:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, 5'($urandom), "random");
        end

        @(posedge clk); #1;
        chk(32'(done), 32'd0, "final_done_pulse");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; operands sampled when accepted.
REQ-005 SHALL have port op  input  2  div_op_t: DIV=0, DIVU=1, REM=2, REMU=3.
REQ-006 SHALL have port dividend  input  XLEN  rs1 value from register file read_data1.
REQ-007 SHALL have port divisor  input  XLEN  rs2 value from register file read_data2.
REQ-008 SHALL have port rd_address  input  5  destination register.
REQ-009 SHALL have port flush  input  1  synchronous abort of in-flight operation.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse; drives register file write_enable.
REQ-012 SHALL have port write_address  output  5  latched rd_address, valid with done.
REQ-013 SHALL have port write_data  output  XLEN  result, valid with done.

Function
REQ-014 SHALL implement states IDLE, CALC, FINISH.
REQ-015 SHALL accept start only in IDLE; start in CALC/FINISH ignored, no queuing.
REQ-016 SHALL, on accept with divisor!=0 and no overflow, latch |operands|, signs, op, rd_address, clear 6-bit counter, enter CALC.
REQ-017 SHALL perform one restoring radix-2 step per CALC cycle: 32 steps, then FINISH.
REQ-018 SHALL assert done exactly one cycle, in FINISH, beginning 33 edges after the accepting edge; then return to IDLE.
REQ-019 SHALL skip CALC for divisor==0: next state FINISH (done one cycle after accept); quotient all-ones, remainder = dividend.
REQ-020 SHALL skip CALC for signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): quotient 0x80000000, remainder 0.
REQ-021 SHALL sign-correct signed results: quotient negative iff operand signs differ; remainder takes dividend sign.
REQ-022 SHALL select quotient for DIV/DIVU, remainder for REM/REMU.
REQ-023 SHALL hold write_data and write_address stable while done high; values undefined-but-known (0) otherwise.
REQ-024 SHALL, on flush in CALC or FINISH, go to IDLE at the next edge with done suppressed in that cycle.
REQ-025 SHALL, on simultaneous flush and start in IDLE, ignore start.
REQ-026 SHALL accept a new start in the cycle after FINISH (IDLE), not during FINISH.

Reset
REQ-027 SHALL, while rst_n low, force state IDLE, busy=0, done=0, write_address=0, write_data=0, counter=0, asynchronously.
REQ-028 SHALL abandon any in-flight operation on reset with no done pulse after release.
REQ-029 SHALL sample start only on edges where rst_n is high.

Structure
REQ-030 SHALL place div_op_t and XLEN in shared package rv_pkg; state enum stays local.
REQ-031 SHALL be a single module; no sub-module needed, iteration step coded inline.

Verification
REQ-032 SHALL cover DIVU 100/7 -> done 33 cycles after accept, write_data=14; REMU same -> 2.
REQ-033 SHALL cover REM -7(0xFFFFFFF9)/2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD; write_address echoes rd_address=5.
REQ-034 SHALL cover DIV 1234/0 -> done 1 cycle after accept, 0xFFFFFFFF; REM 1234/0 -> 1234.
REQ-035 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle; REM -> 0.
REQ-036 SHALL cover flush 10 cycles into CALC -> no done, busy low next cycle; start in CALC ignored; new start afterwards completes correctly.
REQ-037 SHALL cover rst_n low mid-CALC -> busy/done 0 immediately, no done after release.
